data_mem_lsu: RTL and testbench
===============================

# data_mem_lsu

Load/store unit on the initiator side of the data memory in the RV32I multicycle CPU. It accepts one byte, half or word load/store request at a time from the datapath, drives a word-organised memory (combinational read, full-word write on the clock edge), and performs byte-lane alignment, read-modify-write for sub-word stores, and split access for misaligned requests. Loads are returned sign- or zero-extended. Completion is signalled with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, 32: byte-address width; the memory word index is `addr[ADDR_W-1:2]`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in 1: start pulse; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `addr` in 32: byte address, any alignment.
- `wdata` in 32: store data, LSB-justified.
- `ls_ctrl` in 2: size; 00 byte, 01 half, 10 word, 11 illegal.
- `sign_ctrl` in 1: 0 = sign-extend, 1 = zero-extend (loads only; ignored for word).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: pulses with `done` for illegal `ls_ctrl`.
- `rdata` out 32: registered load result; valid from `done`, held until the next load completes.
- `mem_addr` out 32: word-aligned byte address to memory; bits [1:0] are always 0.
- `mem_we` out 1: memory write enable.
- `mem_wdata` out 32: full merged word to memory.
- `mem_rdata` in 32: memory read data, combinational from `mem_addr`.

## Operation
- In IDLE, `req`=1 latches `we`, `addr`, `wdata`, `ls_ctrl`, `sign_ctrl`. Derived values:
  - n = 1, 2 or 4 bytes.
  - o = `addr[1:0]`.
  - split = (o + n > 4).
  - w0 = {`addr[31:2]`, 2'b00}.
  - w1 = w0 + 4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- FSM states: IDLE, RD0, RD1, WR0, WR1, DONE.
  - IDLE: on `req`, go to RD0. If `ls_ctrl`=11, go to DONE with err set and no memory access.
  - RD0: `mem_addr`=w0; capture `mem_rdata` into buf0. Next state is RD1 if split, else WR0 if store, else DONE.
  - RD1: `mem_addr`=w1; capture buf1. Next state is WR0 if store, else DONE.
  - WR0: `mem_addr`=w0; `mem_we`=1. `mem_wdata` = buf0 with byte lanes o..min(o+n,4)-1 replaced by `wdata` bytes 0..; all other lanes are preserved. Next state is WR1 if split, else DONE.
  - WR1: `mem_addr`=w1; `mem_we`=1. Lanes 0..(o+n-5) are replaced by the remaining `wdata` bytes. Next state is DONE.
  - DONE: `done`=1. For a load, `rdata` is loaded on the edge that enters DONE. Return to IDLE.
- Load extraction: take {buf1, buf0} >> 8·o, keep the low n bytes, then extend per `sign_ctrl`. If not split, buf1 is don't-care.
- `mem_we` = (state ∈ {WR0, WR1}) && `rst_n`. No write may occur on the edge where reset is sampled.
- `req` while `busy` is ignored; no queuing. `req` in the same cycle as DONE is also ignored, because the FSM is not in IDLE.
- A store leaves `rdata` unchanged. An illegal request drives `rdata` to 0.
- `mem_addr` is 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `err` 0, `rdata` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.
- Latency is counted as edges from the `req` sample to `done` high:
  - aligned load: 2
  - split load: 3
  - aligned store: 3
  - split store: 5
  - illegal request: 1
- `busy` rises the cycle after `req` is sampled and falls the cycle after `done`.
- A new `req` is accepted no earlier than 1 cycle after `done`.
- Reset mid-operation: the FSM returns to IDLE on the next edge and the access is abandoned with no `done`. Any WR0 already written stays written; WR1 does not occur.

## Test plan
- Aligned `lw` at 0x10 with mem[0x10]=0xDEADBEEF: `done` at edge 2, `rdata`=0xDEADBEEF, `mem_we` never high.
- `lb` at 0x13 with mem[0x10]=0x80FF7F01: with `sign_ctrl`=0, `rdata`=0xFFFFFF80. Then `lbu` at the same address gives 0x00000080.
- `sh` of 0xABCD at 0x21 with mem[0x20]=0x11223344: mem[0x20] becomes 0x11ABCD44; `done` at edge 3.
- Split `sw` of 0xA1B2C3D4 at 0x33 with mem[0x30]=0x00000000 and mem[0x34]=0xFFFFFFFF: mem[0x30]=0xD4000000 and mem[0x34]=0xFFA1B2C3; `done` at edge 5. Reading the result back with a split `lw` at 0x33 gives 0xA1B2C3D4 at edge 3.
- `ls_ctrl`=11: `done` and `err` at edge 1, `rdata`=0, no memory access. A split `lw` at 0xFFFFFFFE reads w1=0x00000000.
- `rst_n` low during WR1 of a split store: no write to w1, FSM in IDLE, all outputs at reset values. `req` during `busy` is ignored, with no second `done`.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Load/store unit for the RV32I multicycle data memory: byte/half/word access with
// lane alignment, read-modify-write for sub-word stores and split misaligned access.
module data_mem_lsu #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [1:0]        ls_ctrl,
   input  logic              sign_ctrl,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_DONE
   } state_t;

   state_t            state;
   logic              we_q, sign_q;
   logic [1:0]        size_q, off_q;
   logic [ADDR_W-3:0] widx_q;
   logic [31:0]       wdata_q, buf0, buf1;

   logic [ADDR_W-3:0] widx_nxt;
   logic [ADDR_W-1:0] w0, w1;
   logic [2:0]        nbytes;
   logic              split;
   logic [7:0]        lane_base, lane_mask;
   logic [63:0]       data_sh, old_pair, new_pair, ld_pair;
   logic [31:0]       ld_val;

   function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [1:0] size, input logic zext);
      logic [31:0] sh;
      sh = 32'(pair >> {off, 3'b000});
      case (size)
         2'b00:   extract = {{24{~zext & sh[7]}}, sh[7:0]};
         2'b01:   extract = {{16{~zext & sh[15]}}, sh[15:0]};
         default: extract = sh;
      endcase
   endfunction

   assign widx_nxt = widx_q + {{(ADDR_W-3){1'b0}}, 1'b1};
   assign w0       = {widx_q, 2'b00};
   assign w1       = {widx_nxt, 2'b00};

   always_comb begin
      nbytes    = 3'd4;
      lane_base = 8'h0F;
      case (size_q)
         2'b00: begin nbytes = 3'd1; lane_base = 8'h01; end
         2'b01: begin nbytes = 3'd2; lane_base = 8'h03; end
         default: ;
      endcase
   end

   assign split     = ({1'b0, off_q} + nbytes) > 3'd4;
   assign lane_mask = lane_base << off_q;

   // Both words are treated as one 64-bit window so a split store is a single merge.
   assign data_sh  = {32'b0, wdata_q} << {off_q, 3'b000};
   assign old_pair = {buf1, buf0};

   always_comb begin
      new_pair = old_pair;
      for (int unsigned i = 0; i < 8; i++) begin
         if (lane_mask[i]) new_pair[i*8 +: 8] = data_sh[i*8 +: 8];
      end
   end

   assign ld_pair = (state == S_RD1) ? {mem_rdata, buf0} : {32'b0, mem_rdata};
   assign ld_val  = extract(ld_pair, off_q, size_q, sign_q);

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_RD0: mem_addr = w0;
         S_RD1: mem_addr = w1;
         S_WR0: begin mem_addr = w0; mem_wdata = new_pair[31:0];  end
         S_WR1: begin mem_addr = w1; mem_wdata = new_pair[63:32]; end
         default: ;
      endcase
   end

   assign mem_we = ((state == S_WR0) || (state == S_WR1)) && rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         we_q    <= 1'b0;
         sign_q  <= 1'b0;
         size_q  <= '0;
         off_q   <= '0;
         widx_q  <= '0;
         wdata_q <= '0;
         buf0    <= '0;
         buf1    <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: if (req) begin
               we_q    <= we;
               sign_q  <= sign_ctrl;
               size_q  <= ls_ctrl;
               off_q   <= addr[1:0];
               widx_q  <= addr[ADDR_W-1:2];
               wdata_q <= wdata;
               busy    <= 1'b1;
               if (ls_ctrl == 2'b11) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
                  rdata <= '0;
               end else begin
                  state <= S_RD0;
               end
            end
            S_RD0: begin
               buf0 <= mem_rdata;
               if (split)     state <= S_RD1;
               else if (we_q) state <= S_WR0;
               else begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  rdata <= ld_val;
               end
            end
            S_RD1: begin
               buf1 <= mem_rdata;
               if (we_q) state <= S_WR0;
               else begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  rdata <= ld_val;
               end
            end
            S_WR0: begin
               if (split) state <= S_WR1;
               else begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_WR1: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized bench for data_mem_lsu against a byte-array memory model and
// per-size latency rules.
module tb_data_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n, req, we, sign_ctrl;
   logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  ls_ctrl;
   logic        busy, done, err, mem_we;

   logic [31:0] mem [256];
   logic [7:0]  ref_b [1024];
   logic [31:0] exp_rdata;
   int unsigned n_checks = 0, n_err = 0, we_cnt = 0, bad_align = 0;

   always #5 clk = ~clk;

   data_mem_lsu #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ls_ctrl(ls_ctrl), .sign_ctrl(sign_ctrl), .busy(busy), .done(done), .err(err),
      .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Memory aliases every 1 KiB, so the top word and word 0 stay distinct.
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

   always @(negedge clk) begin
      if (mem_we) we_cnt++;
      if (mem_addr[1:0] != 2'b00) bad_align++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_word(input int unsigned j, input logic [31:0] v);
      mem[j] = v;
      for (int k = 0; k < 4; k++) ref_b[j*4 + k] = v[k*8 +: 8];
   endtask

   function automatic logic [31:0] model_word(input int unsigned j);
      return {ref_b[j*4+3], ref_b[j*4+2], ref_b[j*4+1], ref_b[j*4]};
   endfunction

   task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic sg, input bit spam);
      int unsigned n, lat_exp, edges, we_before, writes_exp, j0;
      bit          ill, is_split;
      logic [31:0] v, m;
      ill      = (sz == 2'b11);
      n        = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      is_split = (a[1:0] + n) > 4;
      writes_exp = 0;
      if (ill) begin
         exp_rdata = 32'h0;
         lat_exp   = 1;
      end else if (!w) begin
         v = 32'h0;
         for (int unsigned i = 0; i < n; i++) v |= 32'(ref_b[(a + i) & 32'h3FF]) << (8 * i);
         if (!sg && n < 4 && v[8*n-1]) begin
            m = (32'h1 << (8 * n)) - 32'h1;
            v |= ~m;
         end
         exp_rdata = v;
         lat_exp   = is_split ? 3 : 2;
      end else begin
         for (int unsigned i = 0; i < n; i++) ref_b[(a + i) & 32'h3FF] = d[8*i +: 8];
         lat_exp    = is_split ? 5 : 3;
         writes_exp = is_split ? 2 : 1;
      end
      we_before = we_cnt;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; ls_ctrl = sz; sign_ctrl = sg;
      edges = 0;
      do begin
         @(posedge clk); #1;
         edges++;
         if (!spam) req = 1'b0;
         else begin
            addr = $urandom; wdata = $urandom; we = 1'($urandom);
         end
      end while (!done && edges < 20);
      chk("latency", edges, lat_exp);
      chk("err", {31'b0, err}, {31'b0, ill});
      chk("rdata", rdata, exp_rdata);
      @(posedge clk); #1;
      req = 1'b0;
      chk("done_pulse", {31'b0, done}, 32'h0);
      chk("busy_fall", {31'b0, busy}, 32'h0);
      if (spam) begin
         edges = 0;
         repeat (4) begin
            @(posedge clk); #1;
            if (done || busy) edges++;
         end
         chk("spam_ignored", edges, 0);
      end
      chk("writes", we_cnt - we_before, writes_exp);
      chk("rdata_held", rdata, exp_rdata);
      j0 = a[9:2];
      chk("mem_w0", mem[j0], model_word(j0));
      chk("mem_w1", mem[(j0 + 1) % 256], model_word((j0 + 1) % 256));
   endtask

   initial begin
      int unsigned wb;
      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; ls_ctrl = '0; sign_ctrl = 1'b0;
      for (int unsigned j = 0; j < 256; j++) set_word(j, $urandom);
      exp_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      set_word(4, 32'hDEADBEEF);
      do_op(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
      chk("lw_val", rdata, 32'hDEADBEEF);
      set_word(4, 32'h80FF7F01);
      do_op(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 1'b0);
      chk("lb_val", rdata, 32'hFFFFFF80);
      do_op(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 1'b0);
      chk("lbu_val", rdata, 32'h00000080);
      set_word(8, 32'h11223344);
      do_op(1'b1, 32'h21, 32'h0000ABCD, 2'b01, 1'b0, 1'b0);
      chk("sh_mem", mem[8], 32'h11ABCD44);
      set_word(12, 32'h0);
      set_word(13, 32'hFFFFFFFF);
      do_op(1'b1, 32'h33, 32'hA1B2C3D4, 2'b10, 1'b0, 1'b0);
      chk("sw_split_w0", mem[12], 32'hD4000000);
      chk("sw_split_w1", mem[13], 32'hFFA1B2C3);
      do_op(1'b0, 32'h33, 32'h0, 2'b10, 1'b0, 1'b0);
      chk("lw_split_val", rdata, 32'hA1B2C3D4);
      do_op(1'b0, 32'h40, 32'h0, 2'b11, 1'b0, 1'b0);
      do_op(1'b1, 32'h44, 32'h12345678, 2'b11, 1'b0, 1'b0);
      set_word(255, 32'h11223344);
      set_word(0, 32'h55667788);
      do_op(1'b0, 32'hFFFFFFFE, 32'h0, 2'b10, 1'b0, 1'b0);
      chk("lw_wrap_val", rdata, 32'h77881122);
      do_op(1'b0, 32'h13, 32'h0, 2'b01, 1'b0, 1'b1);
      do_op(1'b1, 32'h2E, 32'hCAFEF00D, 2'b10, 1'b0, 1'b1);

      // Reset while the split store sits in WR1: only the first word may change.
      set_word(12, 32'h0);
      set_word(13, 32'hFFFFFFFF);
      ref_b[32'h33] = 8'hD4;
      wb = we_cnt;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h33; wdata = 32'hA1B2C3D4; ls_ctrl = 2'b10; sign_ctrl = 1'b0;
      @(posedge clk); #1; req = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      exp_rdata = 32'h0;
      chk("mid_rst_busy", {31'b0, busy}, 32'h0);
      chk("mid_rst_done", {31'b0, done}, 32'h0);
      chk("mid_rst_rdata", rdata, 32'h0);
      chk("mid_rst_mem_we", {31'b0, mem_we}, 32'h0);
      chk("mid_rst_mem_addr", mem_addr, 32'h0);
      chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
      chk("mid_rst_w0", mem[12], 32'hD4000000);
      chk("mid_rst_w1", mem[13], 32'hFFFFFFFF);
      chk("mid_rst_writes", we_cnt - wb, 1);
      @(negedge clk); rst_n = 1'b1;
      do_op(1'b0, 32'h33, 32'h0, 2'b10, 1'b0, 1'b0);

      for (int k = 0; k < 150; k++) begin
         logic [31:0] ra;
         ra = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFFC + $urandom_range(0, 3))
                                         : $urandom_range(0, 1023);
         do_op(1'($urandom), ra, $urandom, 2'($urandom_range(0, 3)), 1'($urandom),
               ($urandom_range(0, 7) == 0));
      end

      chk("addr_align", bad_align, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
